// File: rtl/idex_reg.sv
// ID/EX pipeline register: registers decode fields for execute, inserts bubbles on
// flush or load-use hazard, and keeps a saturating count of hazard bubbles.
module idex_reg #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             advance,
    input  logic             flush,
    input  logic [31:0]      pcplus4_in,
    input  logic [31:0]      rdat1_in,
    input  logic [31:0]      rdat2_in,
    input  logic [31:0]      immext_in,
    input  logic [4:0]       rs_in,
    input  logic [4:0]       rt_in,
    input  logic [4:0]       rd_in,
    input  logic             uses_rt_in,
    input  logic [3:0]       AluOp_in,
    input  logic             MemToReg_in,
    input  logic             AluSrc_in,
    input  logic             JType_in,
    input  logic             RegDst_in,
    input  logic             regWEN_in,
    input  logic             PcSrc_in,
    input  logic             JReg_in,
    input  logic             Halt_in,
    input  logic             dMemWEN_in,
    input  logic             dMemREN_in,
    output logic [31:0]      pcplus4_out,
    output logic [31:0]      rdat1_out,
    output logic [31:0]      rdat2_out,
    output logic [31:0]      immext_out,
    output logic [4:0]       rs_out,
    output logic [4:0]       rt_out,
    output logic [4:0]       rd_out,
    output logic [3:0]       AluOp_out,
    output logic             MemToReg_out,
    output logic             AluSrc_out,
    output logic             JType_out,
    output logic             RegDst_out,
    output logic             regWEN_out,
    output logic             PcSrc_out,
    output logic             JReg_out,
    output logic             Halt_out,
    output logic             dMemWEN_out,
    output logic             dMemREN_out,
    output logic             valid_out,
    output logic             load_use_stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam int PW = 157;

    logic [PW-1:0]    payload_in_s;
    logic [PW-1:0]    payload_d;
    logic [PW-1:0]    payload_q;
    logic             valid_d;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             rt_match_s;
    logic             stall_s;

    // The all-zero payload is the bubble, so flush and hazard simply load zeros.
    assign payload_in_s = {pcplus4_in, rdat1_in, rdat2_in, immext_in,
                           rs_in, rt_in, rd_in, AluOp_in,
                           MemToReg_in, AluSrc_in, JType_in, RegDst_in, regWEN_in,
                           PcSrc_in, JReg_in, Halt_in, dMemWEN_in, dMemREN_in};

    assign {pcplus4_out, rdat1_out, rdat2_out, immext_out,
            rs_out, rt_out, rd_out, AluOp_out,
            MemToReg_out, AluSrc_out, JType_out, RegDst_out, regWEN_out,
            PcSrc_out, JReg_out, Halt_out, dMemWEN_out, dMemREN_out} = payload_q;

    assign valid_out      = valid_q;
    assign bubble_cnt     = cnt_q;
    assign load_use_stall = stall_s;

    // Load-use hazard detection against the load currently held in EX.
    always_comb begin
        rt_match_s = (rt_out == rs_in) | (uses_rt_in & (rt_out == rt_in));
        stall_s    = valid_q & dMemREN_out & regWEN_out & (rt_out != 5'd0)
                     & rt_match_s & ~flush;
    end

    // Next-state selection: flush, hazard bubble, advance, or hold.
    always_comb begin
        payload_d = payload_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        if (flush) begin
            payload_d = '0;
            valid_d   = 1'b0;
        end else if (advance && stall_s) begin
            payload_d = '0;
            valid_d   = 1'b0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
        end else if (advance) begin
            payload_d = payload_in_s;
            valid_d   = 1'b1;
        end else begin
            payload_d = payload_q;
            valid_d   = valid_q;
        end
    end

    // State registers with asynchronous active-low reset to the bubble value.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            payload_q <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            payload_q <= payload_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule
